// File: rtl/dlx_mem_pkg.sv
// Shared types and constants for the DLX instruction/data SRAM arbiter.
package dlx_mem_pkg;

    localparam int unsigned WORD_W = 32;
    localparam logic [31:0] WORD_ALIGN_MASK = 32'hFFFF_FFFC;

    typedef enum logic [1:0] {
        StIdle,
        StAccess,
        StResp
    } state_e;

    typedef enum logic {
        GntI,
        GntD
    } gnt_e;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & WORD_ALIGN_MASK;
    endfunction

endpackage

// File: rtl/dlx_mem_arbiter_if.sv
// Fetch port, data port and SRAM bus of the DLX memory arbiter.
interface dlx_mem_arbiter_if;
    import dlx_mem_pkg::*;

    logic                if_req;
    logic [31:0]         if_addr;
    logic [0:WORD_W-1]   if_rdata;
    logic                if_ack;

    logic                dm_req;
    logic                dm_we;
    logic [31:0]         dm_addr;
    logic [0:WORD_W-1]   dm_wdata;
    logic [0:WORD_W-1]   dm_rdata;
    logic                dm_ack;

    logic                sram_cs;
    logic                sram_oe;
    logic                sram_we;
    logic [31:0]         sram_addr;
    logic [0:WORD_W-1]   sram_din;
    logic [0:WORD_W-1]   sram_dout;

    logic                busy;

    modport slave (
        input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, sram_dout,
        output if_rdata, if_ack, dm_rdata, dm_ack,
        output sram_cs, sram_oe, sram_we, sram_addr, sram_din, busy
    );

    modport master (
        output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, sram_dout,
        input  if_rdata, if_ack, dm_rdata, dm_ack,
        input  sram_cs, sram_oe, sram_we, sram_addr, sram_din, busy
    );

endinterface

// File: rtl/dlx_mem_wait_ctr.sv
// Loadable down-counter with a zero flag; holds at zero once reached.
module dlx_mem_wait_ctr #(
    parameter int unsigned Width = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load_i,
    input  logic [Width-1:0] load_val_i,
    input  logic             dec_i,
    output logic             zero_o
);

    logic [Width-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/dlx_mem_arbiter.sv
// Single-port SRAM arbiter between DLX fetch and data stages: data has priority,
// with a starvation guard that forces a fetch grant after a run of data grants.
module dlx_mem_arbiter
    import dlx_mem_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES  = 1,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input logic              clk,
    input logic              reset_n,
    dlx_mem_arbiter_if.slave bus
);

    localparam int unsigned CtrW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam int unsigned StW  = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

    state_e              state_q, state_d;
    gnt_e                gnt_q, gnt_d;
    logic                we_q, we_d;
    logic [31:0]         addr_q, addr_d;
    logic [0:WORD_W-1]   wdata_q, wdata_d;
    logic [0:WORD_W-1]   if_rdata_q, if_rdata_d;
    logic [0:WORD_W-1]   dm_rdata_q, dm_rdata_d;
    logic [StW-1:0]      starve_q, starve_d;

    logic ctr_load, ctr_dec, ctr_zero;
    logic starved;

    dlx_mem_wait_ctr #(
        .Width (CtrW)
    ) u_wait_ctr (
        .clk        (clk),
        .reset_n    (reset_n),
        .load_i     (ctr_load),
        .load_val_i (CtrW'(WAIT_CYCLES)),
        .dec_i      (ctr_dec),
        .zero_o     (ctr_zero)
    );

    assign starved = (starve_q == StW'(STARVE_LIMIT));

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        if_rdata_d = if_rdata_q;
        dm_rdata_d = dm_rdata_q;
        starve_d   = starve_q;
        ctr_load   = 1'b0;
        ctr_dec    = 1'b0;

        case (state_q)
            StIdle: begin
                if (bus.if_req && (starved || !bus.dm_req)) begin
                    gnt_d    = GntI;
                    we_d     = 1'b0;
                    addr_d   = word_align(bus.if_addr);
                    starve_d = '0;
                    ctr_load = 1'b1;
                    state_d  = StAccess;
                end else if (bus.dm_req) begin
                    gnt_d    = GntD;
                    we_d     = bus.dm_we;
                    addr_d   = word_align(bus.dm_addr);
                    wdata_d  = bus.dm_wdata;
                    ctr_load = 1'b1;
                    state_d  = StAccess;
                    // Count only data grants that left a fetch waiting.
                    if (bus.if_req && !starved) begin
                        starve_d = starve_q + 1'b1;
                    end
                end
                if (!bus.if_req) begin
                    starve_d = '0;
                end
            end
            StAccess: begin
                if (ctr_zero) begin
                    if (!we_q) begin
                        if (gnt_q == GntI) begin
                            if_rdata_d = bus.sram_dout;
                        end else begin
                            dm_rdata_d = bus.sram_dout;
                        end
                    end
                    state_d = StResp;
                end else begin
                    ctr_dec = 1'b1;
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            gnt_q      <= GntI;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
            starve_q   <= '0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            if_rdata_q <= if_rdata_d;
            dm_rdata_q <= dm_rdata_d;
            starve_q   <= starve_d;
        end
    end

    // SRAM controls decode straight from state so a reset drops them at that edge.
    assign bus.sram_cs   = (state_q == StAccess);
    assign bus.sram_oe   = (state_q == StAccess) && !we_q;
    assign bus.sram_we   = (state_q == StAccess) && we_q;
    assign bus.sram_addr = addr_q;
    assign bus.sram_din  = wdata_q;

    assign bus.if_ack    = (state_q == StResp) && (gnt_q == GntI);
    assign bus.dm_ack    = (state_q == StResp) && (gnt_q == GntD);
    assign bus.if_rdata  = if_rdata_q;
    assign bus.dm_rdata  = dm_rdata_q;
    assign bus.busy      = (state_q != StIdle);

endmodule

// File: tb/tb_dlx_mem_arbiter.sv
// Directed bench: per-cycle vector table on a WAIT_CYCLES=0 arbiter, plus
// starvation and WAIT_CYCLES=2 sequences.
module tb_dlx_mem_arbiter;

    logic clk = 1'b0;
    logic rst_n0;
    logic rst_n2;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    dlx_mem_arbiter_if bus0 ();
    dlx_mem_arbiter_if bus2 ();

    dlx_mem_arbiter #(
        .WAIT_CYCLES  (0),
        .STARVE_LIMIT (4)
    ) u_dut0 (
        .clk     (clk),
        .reset_n (rst_n0),
        .bus     (bus0)
    );

    dlx_mem_arbiter #(
        .WAIT_CYCLES  (2),
        .STARVE_LIMIT (4)
    ) u_dut2 (
        .clk     (clk),
        .reset_n (rst_n2),
        .bus     (bus2)
    );

    // ctl = {if_ack, dm_ack, sram_cs, sram_oe, sram_we, busy}
    typedef struct {
        string       name;
        logic        rst_n;
        logic        if_req;
        logic [31:0] if_addr;
        logic        dm_req;
        logic        dm_we;
        logic [31:0] dm_addr;
        logic [31:0] dm_wdata;
        logic [31:0] dout;
        logic [5:0]  e_ctl;
        logic [31:0] e_addr;
        logic [31:0] e_din;
        logic [31:0] e_ird;
        logic [31:0] e_drd;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input string name, input logic rst_n, input logic if_req,
                                input logic [31:0] if_addr, input logic dm_req,
                                input logic dm_we, input logic [31:0] dm_addr,
                                input logic [31:0] dm_wdata, input logic [31:0] dout,
                                input logic [5:0] e_ctl, input logic [31:0] e_addr,
                                input logic [31:0] e_din, input logic [31:0] e_ird,
                                input logic [31:0] e_drd);
        vec_t v;
        v.name = name;   v.rst_n = rst_n;       v.if_req = if_req;   v.if_addr = if_addr;
        v.dm_req = dm_req; v.dm_we = dm_we;     v.dm_addr = dm_addr; v.dm_wdata = dm_wdata;
        v.dout = dout;   v.e_ctl = e_ctl;       v.e_addr = e_addr;   v.e_din = e_din;
        v.e_ird = e_ird; v.e_drd = e_drd;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    initial begin
        logic [5:0]  a_ctl;
        logic [31:0] a_addr, a_din, a_ird, a_drd;
        int          order[6];
        int          n_ack, both_ack;
        int          ack_k, cs_cnt, oe_cnt, we_cnt, addr_ok;
        logic        cs_at_ack, busy_k0;

        rst_n0 = 1'b0; rst_n2 = 1'b0;
        bus0.if_req = 0; bus0.if_addr = 0; bus0.dm_req = 0; bus0.dm_we = 0;
        bus0.dm_addr = 0; bus0.dm_wdata = 0; bus0.sram_dout = 0;
        bus2.if_req = 0; bus2.if_addr = 0; bus2.dm_req = 0; bus2.dm_we = 0;
        bus2.dm_addr = 0; bus2.dm_wdata = 0; bus2.sram_dout = 0;

        // name, rst_n, if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, dout,
        // ctl, sram_addr, sram_din, if_rdata, dm_rdata
        vecs.push_back(mk("reset", 0, 0, 0, 0, 0, 0, 0, 0, 6'b000000, 0, 0, 0, 0));
        vecs.push_back(mk("fetch_req", 1, 1, 32'h10, 0, 0, 0, 0, 32'h0C000080,
                          6'b000000, 0, 0, 0, 0));
        vecs.push_back(mk("fetch_access", 1, 1, 32'h10, 0, 0, 0, 0, 32'h0C000080,
                          6'b001101, 32'h10, 0, 0, 0));
        vecs.push_back(mk("fetch_ack", 1, 1, 32'h10, 0, 0, 0, 0, 32'h0C000080,
                          6'b100001, 32'h10, 0, 32'h0C000080, 0));
        vecs.push_back(mk("fetch_idle", 1, 0, 0, 0, 0, 0, 0, 0,
                          6'b000000, 32'h10, 0, 32'h0C000080, 0));
        vecs.push_back(mk("store_req", 1, 0, 0, 1, 1, 32'h80, 32'hF0F077F0, 0,
                          6'b000000, 32'h10, 0, 32'h0C000080, 0));
        vecs.push_back(mk("store_access", 1, 0, 0, 1, 1, 32'h44, 32'h12345678, 32'hDEADBEEF,
                          6'b001011, 32'h80, 32'hF0F077F0, 32'h0C000080, 0));
        vecs.push_back(mk("store_ack", 1, 0, 0, 1, 1, 32'h80, 32'hF0F077F0, 32'hDEADBEEF,
                          6'b010001, 32'h80, 32'hF0F077F0, 32'h0C000080, 0));
        vecs.push_back(mk("simul_req", 1, 1, 32'h20, 1, 0, 32'h84, 0, 0,
                          6'b000000, 32'h80, 32'hF0F077F0, 32'h0C000080, 0));
        vecs.push_back(mk("load_access", 1, 1, 32'h20, 1, 0, 32'h84, 0, 32'hA5A50001,
                          6'b001101, 32'h84, 0, 32'h0C000080, 0));
        vecs.push_back(mk("load_ack", 1, 1, 32'h20, 1, 0, 32'h84, 0, 32'hA5A50001,
                          6'b010001, 32'h84, 0, 32'h0C000080, 32'hA5A50001));
        vecs.push_back(mk("fetch_after_load", 1, 1, 32'h20, 0, 0, 0, 0, 0,
                          6'b000000, 32'h84, 0, 32'h0C000080, 32'hA5A50001));
        vecs.push_back(mk("fetch2_access", 1, 1, 32'h20, 0, 0, 0, 0, 32'h00000F0F,
                          6'b001101, 32'h20, 0, 32'h0C000080, 32'hA5A50001));
        vecs.push_back(mk("fetch2_ack", 1, 1, 32'h20, 0, 0, 0, 0, 32'h00000F0F,
                          6'b100001, 32'h20, 0, 32'h00000F0F, 32'hA5A50001));
        vecs.push_back(mk("idle2", 1, 0, 0, 0, 0, 0, 0, 0,
                          6'b000000, 32'h20, 0, 32'h00000F0F, 32'hA5A50001));
        vecs.push_back(mk("rst_store_req", 1, 0, 0, 1, 1, 32'h100, 32'h11112222, 0,
                          6'b000000, 32'h20, 0, 32'h00000F0F, 32'hA5A50001));
        vecs.push_back(mk("rst_in_access", 0, 0, 0, 1, 1, 32'h100, 32'h11112222, 0,
                          6'b001011, 32'h100, 32'h11112222, 32'h00000F0F, 32'hA5A50001));
        vecs.push_back(mk("after_reset", 1, 0, 0, 0, 0, 0, 0, 0, 6'b000000, 0, 0, 0, 0));
        vecs.push_back(mk("fetch3_req", 1, 1, 32'h0B, 0, 0, 0, 0, 32'h22223333,
                          6'b000000, 0, 0, 0, 0));
        vecs.push_back(mk("fetch3_access", 1, 1, 32'h0B, 0, 0, 0, 0, 32'h22223333,
                          6'b001101, 32'h08, 0, 0, 0));
        vecs.push_back(mk("fetch3_ack", 1, 1, 32'h0B, 0, 0, 0, 0, 32'h22223333,
                          6'b100001, 32'h08, 0, 32'h22223333, 0));
        vecs.push_back(mk("idle3", 1, 0, 0, 0, 0, 0, 0, 0,
                          6'b000000, 32'h08, 0, 32'h22223333, 0));

        repeat (2) @(posedge clk);

        foreach (vecs[i]) begin
            #1;
            rst_n0 = vecs[i].rst_n;
            bus0.if_req = vecs[i].if_req;   bus0.if_addr = vecs[i].if_addr;
            bus0.dm_req = vecs[i].dm_req;   bus0.dm_we = vecs[i].dm_we;
            bus0.dm_addr = vecs[i].dm_addr; bus0.dm_wdata = vecs[i].dm_wdata;
            bus0.sram_dout = vecs[i].dout;
            @(negedge clk);
            a_ctl  = {bus0.if_ack, bus0.dm_ack, bus0.sram_cs, bus0.sram_oe, bus0.sram_we,
                      bus0.busy};
            a_addr = bus0.sram_addr; a_din = bus0.sram_din;
            a_ird  = bus0.if_rdata;  a_drd = bus0.dm_rdata;
            checks++;
            if ({a_ctl, a_addr, a_din, a_ird, a_drd} !==
                {vecs[i].e_ctl, vecs[i].e_addr, vecs[i].e_din, vecs[i].e_ird, vecs[i].e_drd})
            begin
                failures++;
                $display("FAIL %s: got ctl=%06b addr=%08h din=%08h ird=%08h drd=%08h, expected ctl=%06b addr=%08h din=%08h ird=%08h drd=%08h",
                         vecs[i].name, a_ctl, a_addr, a_din, a_ird, a_drd, vecs[i].e_ctl,
                         vecs[i].e_addr, vecs[i].e_din, vecs[i].e_ird, vecs[i].e_drd);
            end
            @(posedge clk);
        end

        // Starvation: both ports request continuously; expect D D D D I D.
        #1;
        bus0.dm_req = 1; bus0.dm_we = 0; bus0.dm_addr = 32'h40;
        bus0.if_req = 1; bus0.if_addr = 32'h50; bus0.sram_dout = 32'h77;
        foreach (order[i]) order[i] = 2;
        n_ack = 0; both_ack = 0;
        for (int c = 0; c < 60 && n_ack < 6; c++) begin
            @(negedge clk);
            if (bus0.if_ack && bus0.dm_ack) both_ack++;
            if (bus0.dm_ack) begin
                order[n_ack] = 1; n_ack++;
            end else if (bus0.if_ack) begin
                order[n_ack] = 0; n_ack++;
            end
            @(posedge clk);
            #1;
        end
        bus0.dm_req = 0; bus0.if_req = 0;
        chk("starve_ack_count", n_ack, 6);
        chk("starve_grant0_d", order[0], 1);
        chk("starve_grant1_d", order[1], 1);
        chk("starve_grant2_d", order[2], 1);
        chk("starve_grant3_d", order[3], 1);
        chk("starve_grant4_i", order[4], 0);
        chk("starve_grant5_d", order[5], 1);
        chk("starve_no_dual_ack", both_ack, 0);

        // WAIT_CYCLES=2 load at unaligned 0x87: 3 access cycles, ack at T+4.
        @(posedge clk);
        #1;
        rst_n2 = 1;
        bus2.dm_req = 1; bus2.dm_we = 0; bus2.dm_addr = 32'h87; bus2.sram_dout = 32'hCAFE0001;
        ack_k = -1; cs_cnt = 0; oe_cnt = 0; we_cnt = 0; addr_ok = 0;
        cs_at_ack = 1'b1; busy_k0 = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (k == 0) busy_k0 = bus2.busy;
            if (bus2.sram_cs) begin
                cs_cnt++;
                if (bus2.sram_addr == 32'h84) addr_ok++;
            end
            if (bus2.sram_oe) oe_cnt++;
            if (bus2.sram_we) we_cnt++;
            if (bus2.dm_ack && ack_k < 0) begin
                ack_k = k;
                cs_at_ack = bus2.sram_cs;
            end
            @(posedge clk);
            #1;
            if (ack_k >= 0) bus2.dm_req = 0;
        end
        chk("w2_idle_not_busy", {31'd0, busy_k0}, 0);
        chk("w2_ack_cycle", ack_k, 4);
        chk("w2_cs_cycles", cs_cnt, 3);
        chk("w2_oe_cycles", oe_cnt, 3);
        chk("w2_we_cycles", we_cnt, 0);
        chk("w2_aligned_addr_cycles", addr_ok, 3);
        chk("w2_cs_low_in_resp", {31'd0, cs_at_ack}, 0);
        chk("w2_dm_rdata", bus2.dm_rdata, 32'hCAFE0001);
        chk("w2_if_rdata_untouched", bus2.if_rdata, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
